// File: rtl/mem_stage_sram.sv
// mem_stage_sram: MEM stage of the 5-stage ARM pipeline. Each LDR/STR becomes
// two 16-bit SRAM accesses (low half, then high half). Each access lasts
// WAIT_CYCLES cycles. The pipeline is frozen while the access runs.
// Optional build macro MEM_RANGE_CHECK_EN enables address checking and the
// sticky err flag.
module mem_stage_sram #(
  parameter int N           = 32,
  parameter int AW          = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE        = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          WB_ENIn,
  input  logic          MEM_R_ENIn,
  input  logic          MEM_W_ENIn,
  input  logic [3:0]    DestIn,
  input  logic [N-1:0]  ALU_ResIn,
  input  logic [N-1:0]  Val_RmIn,
  output logic          WB_ENOut,
  output logic          MEM_R_ENOut,
  output logic [3:0]    DestOut,
  output logic [N-1:0]  ALU_ResOut,
  output logic [N-1:0]  DataMemoryOut,
  output logic          ready,
  output logic          err,
  output logic [AW-1:0] sram_addr,
  output logic [15:0]   sram_dq_out,
  input  logic [15:0]   sram_dq_in,
  output logic          sram_dq_oe,
  output logic          sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  localparam logic [N-1:0] L_BASE  = N'(BASE);
  localparam logic [3:0]   L_WLOAD = 4'(WAIT_CYCLES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [N-1:0]  r_data;
  logic [N-1:0]  w_off;
  logic          w_req;
  logic          w_bad;
  logic          w_hi;
  logic          w_last;

  assign WB_ENOut      = WB_ENIn;
  assign MEM_R_ENOut   = MEM_R_ENIn;
  assign DestOut       = DestIn;
  assign ALU_ResOut    = ALU_ResIn;
  assign DataMemoryOut = r_data;

  assign w_req  = MEM_R_ENIn | MEM_W_ENIn;
  assign w_off  = ALU_ResIn - L_BASE;
  assign w_last = (r_cnt == '0);
  assign w_hi   = (r_state == S_RD_HI) || (r_state == S_WR_HI);

`ifdef MEM_RANGE_CHECK_EN
  assign w_bad = (ALU_ResIn < L_BASE) || (w_off[1:0] != 2'b00) || (|w_off[N-1:AW+1]);
`else
  logic w_unused_off;
  assign w_unused_off = ^{w_off[N-1:AW+1], w_off[1:0]};
  assign w_bad        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Wait counter: reload on every state change, count down while the state holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= L_WLOAD;
    else if (!w_last)           r_cnt <= r_cnt - 4'd1;
  end

  // Next-state logic; a read wins over a simultaneous write
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_bad)           w_next = S_DONE;
          else if (MEM_R_ENIn) w_next = S_RD_LO;
          else                 w_next = S_WR_LO;
        end
      end
      S_RD_LO: if (w_last) w_next = S_RD_HI;
      S_RD_HI: if (w_last) w_next = S_DONE;
      S_WR_LO: if (w_last) w_next = S_WR_HI;
      S_WR_HI: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and SRAM pin drive
  always_comb begin
    ready       = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = '0;
    sram_addr   = '0;
    if (rst) sram_addr = {w_off[AW:2], w_hi};
    if (r_state == S_WR_LO) begin
      sram_we_n   = 1'b0;
      sram_dq_oe  = 1'b1;
      sram_dq_out = Val_RmIn[15:0];
    end else if (r_state == S_WR_HI) begin
      sram_we_n   = 1'b0;
      sram_dq_oe  = 1'b1;
      sram_dq_out = Val_RmIn[31:16];
    end
  end

  // Load data register: each half is captured on the last wait cycle of its phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (r_state == S_RD_LO && w_last) begin
      r_data[15:0] <= sram_dq_in;
    end else if (r_state == S_RD_HI && w_last) begin
      r_data[31:16] <= sram_dq_in;
    end else if (r_state == S_IDLE && MEM_R_ENIn && w_bad) begin
      r_data <= '0;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic r_err;
  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_err <= 1'b0;
    else if (r_state == S_IDLE && w_req && w_bad) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed testbench for mem_stage_sram with a 64-word SRAM model.
module tb_mem_stage_sram;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_ENIn, MEM_R_ENIn, MEM_W_ENIn;
  logic [3:0]  DestIn;
  logic [31:0] ALU_ResIn, Val_RmIn;
  logic        WB_ENOut, MEM_R_ENOut;
  logic [3:0]  DestOut;
  logic [31:0] ALU_ResOut, DataMemoryOut;
  logic        ready, err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic [15:0] mem [0:63];
  int n_checks = 0;
  int n_fail   = 0;
  int lows_a, lows_b;

  mem_stage_sram #(.N(32), .AW(18), .WAIT_CYCLES(W), .BASE(1024)) dut (
    .clk(clk), .rst(rst),
    .WB_ENIn(WB_ENIn), .MEM_R_ENIn(MEM_R_ENIn), .MEM_W_ENIn(MEM_W_ENIn),
    .DestIn(DestIn), .ALU_ResIn(ALU_ResIn), .Val_RmIn(Val_RmIn),
    .WB_ENOut(WB_ENOut), .MEM_R_ENOut(MEM_R_ENOut), .DestOut(DestOut),
    .ALU_ResOut(ALU_ResOut), .DataMemoryOut(DataMemoryOut),
    .ready(ready), .err(err),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write on the clock edge while we_n is low
  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_req();
    WB_ENIn = 1'b0; MEM_R_ENIn = 1'b0; MEM_W_ENIn = 1'b0;
  endtask

  // Called at cycle 0 (just after a clock edge); returns at the DONE cycle.
  task automatic do_access(input string nm, input bit wr, input logic [31:0] addr_b,
                           input logic [31:0] wdata, input logic [17:0] a_lo,
                           input logic [31:0] exp_rd, output int lows);
    bit in_lo, in_hi;
    WB_ENIn = !wr; MEM_R_ENIn = !wr; MEM_W_ENIn = wr;
    DestIn = 4'd5; ALU_ResIn = addr_b; Val_RmIn = wdata;
    lows = 0;
    for (int k = 0; k <= 2*W+1; k++) begin
      if (k > 0) step();
      @(negedge clk);
      if (!ready) lows++;
      in_lo = (k >= 1) && (k <= W);
      in_hi = (k > W) && (k <= 2*W);
      chk({nm, ".ready"}, ready, (k == 2*W+1));
      chk({nm, ".we_n"}, sram_we_n, !(wr && (in_lo || in_hi)));
      chk({nm, ".oe"}, sram_dq_oe, (wr && (in_lo || in_hi)));
      if (in_lo) chk({nm, ".addr_lo"}, sram_addr, a_lo);
      if (in_hi) chk({nm, ".addr_hi"}, sram_addr, a_lo + 18'd1);
      if (wr && in_lo) chk({nm, ".dq_lo"}, sram_dq_out, wdata[15:0]);
      if (wr && in_hi) chk({nm, ".dq_hi"}, sram_dq_out, wdata[31:16]);
    end
    if (!wr) chk({nm, ".rdata"}, DataMemoryOut, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    no_req();
    DestIn = 4'd0; ALU_ResIn = 32'd1028; Val_RmIn = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", ready, 1'b1);
    chk("rst.we_n", sram_we_n, 1'b1);
    chk("rst.oe", sram_dq_oe, 1'b0);
    chk("rst.addr", sram_addr, 18'd0);
    chk("rst.data", DataMemoryOut, 32'h0);
    chk("rst.err", err, 1'b0);
    step();
    rst = 1'b1;

    // 1. Store 0xDEADBEEF to 1028 -> half-words 2,3
    step();
    do_access("str1", 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0, lows_a);
    chk("str1.lows", lows_a, 5);
    chk("str1.data_untouched", DataMemoryOut, 32'h0);
    step(); no_req();
    @(negedge clk);
    chk("idle.ready", ready, 1'b1);

    // 2. Load it back
    step();
    do_access("ldr1", 1'b0, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF, lows_a);
    chk("ldr1.lows", lows_a, 5);

    // 3. Non-memory instruction passes straight through
    step();
    no_req(); WB_ENIn = 1'b1; ALU_ResIn = 32'h55; DestIn = 4'd3;
    #1;
    chk("alu.ready", ready, 1'b1);
    chk("alu.wb", WB_ENOut, 1'b1);
    chk("alu.mr", MEM_R_ENOut, 1'b0);
    chk("alu.res", ALU_ResOut, 32'h55);
    chk("alu.dest", DestOut, 4'd3);
    step();
    @(negedge clk);
    chk("alu.ready2", ready, 1'b1);
    chk("alu.we_n", sram_we_n, 1'b1);
    chk("alu.hold", DataMemoryOut, 32'hDEADBEEF);

    // 4. Back-to-back LDR then STR, then read the store back
    step();
    do_access("b2b_ld", 1'b0, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF, lows_a);
    step();
    do_access("b2b_st", 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4, 32'h0, lows_b);
    chk("b2b.lows", lows_a + lows_b, 10);
    step();
    do_access("b2b_rb", 1'b0, 32'd1032, 32'h0, 18'd4, 32'hCAFEF00D, lows_a);

    // 5. Reset during the high half of a store
    step();
    WB_ENIn = 1'b0; MEM_R_ENIn = 1'b0; MEM_W_ENIn = 1'b1;
    ALU_ResIn = 32'd1032; Val_RmIn = 32'h12345678;
    repeat (3) step();
    rst = 1'b0; no_req();
    #1;
    chk("mrst.we_n", sram_we_n, 1'b1);
    chk("mrst.ready", ready, 1'b1);
    chk("mrst.data", DataMemoryOut, 32'h0);
    chk("mrst.addr", sram_addr, 18'd0);
    chk("mrst.oe", sram_dq_oe, 1'b0);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mrst.idle_ready", ready, 1'b1);
    chk("mrst.idle_we_n", sram_we_n, 1'b1);
    chk("mrst.mem_lo", mem[4], 16'h5678);
    chk("mrst.mem_hi", mem[5], 16'hCAFE);
    step();
    do_access("mrst_ld", 1'b0, 32'd1032, 32'h0, 18'd4, 32'hCAFE5678, lows_a);
    chk("mrst_ld.lows", lows_a, 5);

    // 6. Misaligned load from 1026
    step();
    do_access("pre", 1'b1, 32'd1024, 32'h22221111, 18'd0, 32'h0, lows_a);
    step();
`ifdef MEM_RANGE_CHECK_EN
    WB_ENIn = 1'b1; MEM_R_ENIn = 1'b1; MEM_W_ENIn = 1'b0; ALU_ResIn = 32'd1026;
    @(negedge clk);
    chk("rng.ready0", ready, 1'b0);
    chk("rng.we_n0", sram_we_n, 1'b1);
    step();
    @(negedge clk);
    chk("rng.ready1", ready, 1'b1);
    chk("rng.err", err, 1'b1);
    chk("rng.data", DataMemoryOut, 32'h0);
    chk("rng.we_n1", sram_we_n, 1'b1);
    chk("rng.oe", sram_dq_oe, 1'b0);
    step(); no_req();
    @(negedge clk);
    chk("rng.err_sticky", err, 1'b1);
`else
    do_access("rng", 1'b0, 32'd1026, 32'h0, 18'd0, 32'h22221111, lows_a);
    chk("rng.lows", lows_a, 5);
    chk("rng.err", err, 1'b0);
    step(); no_req();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Memory-access stage of the ARM 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns LDR/STR requests into two 16-bit accesses on the off-chip SRAM, with a programmable number of wait cycles per access. It drives `ready` low to freeze the whole pipeline while an access is in progress. Its outputs feed the MEM/WB register inputs directly.

## Interface
- `N`, 32: datapath width.
- `AW`, 18: SRAM half-word address width.
- `WAIT_CYCLES`, 2: cycles per SRAM half-word access, legal 1..15.
- `BASE`, 1024: byte address mapped to SRAM half-word 0.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `WB_ENIn`, `MEM_R_ENIn`, `MEM_W_ENIn` in 1: control bits from EX/MEM.
- `DestIn` in 4: destination register number.
- `ALU_ResIn` in N: byte address for memory ops, otherwise the ALU result.
- `Val_RmIn` in N: store data.
- `WB_ENOut`, `MEM_R_ENOut` out 1: go to MEM/WB.
- `DestOut` out 4: goes to MEM/WB.
- `ALU_ResOut` out N: goes to MEM/WB.
- `DataMemoryOut` out N: registered load data, to MEM/WB.
- `ready` out 1: high means the pipeline may advance; low means freeze all pipeline registers and the PC.
- `err` out 1: sticky access-error flag (see Configuration).
- `sram_addr` out AW: SRAM half-word address.
- `sram_dq_out` out 16: write data.
- `sram_dq_in` in 16: read data.
- `sram_dq_oe` out 1: drive enable for the external tristate.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- Pass-through signals:
  - `WB_ENOut`, `MEM_R_ENOut`, `DestOut` and `ALU_ResOut` are combinational copies of their inputs.
  - MEM/WB captures them only while `ready`=1.
- Request: `req` = `MEM_R_ENIn` | `MEM_W_ENIn`. If both are set, the read wins and the write is ignored.
- Address:
  - off = `ALU_ResIn` − `BASE`.
  - `sram_addr` = {off[AW:2], h}, where h=0 selects bits 15:0 (low half) and h=1 selects bits 31:16 (high half).
  - off[1:0] is ignored unless `MEM_RANGE_CHECK_EN` is defined.
- State machine states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE: no request → stay. On read → RD_LO. On write → WR_LO.
  - RD_LO: lasts WAIT_CYCLES cycles. On the last cycle, latch `sram_dq_in` into data[15:0], then → RD_HI.
  - RD_HI: lasts WAIT_CYCLES cycles. On the last cycle, latch into data[31:16], then → DONE.
  - WR_LO and WR_HI: same durations as the read states. WR_LO → WR_HI → DONE.
  - DONE: exactly one cycle, then → IDLE unconditionally. DONE never re-triggers on the still-present request.
- Wait counter: 4-bit down-counter. It loads WAIT_CYCLES−1 on every state entry; the state advances when it reaches 0.
- `ready` = (IDLE & !req) | DONE.
- SRAM outputs:
  - In WR_*: `sram_we_n`=0, `sram_dq_oe`=1, and `sram_dq_out` = `Val_RmIn`[15:0] in WR_LO or [31:16] in WR_HI.
  - In every other state: `sram_we_n`=1, `sram_dq_oe`=0.
- `DataMemoryOut` = data register. It holds its value until the next read overwrites it; writes do not change it.
- Reset (rst=0), at any time including mid-access:
  - State goes to IDLE, counter 0, data 0, `err` 0.
  - `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0 while in reset.
  - No partial write is completed after release.

## Timing
- Let W = WAIT_CYCLES. Cycle 0 is the cycle in which a request is present in IDLE.
- Cycle 0: `ready`=0.
- Low-half access: cycles 1..W.
- High-half access: cycles W+1..2W.
- DONE: cycle 2W+1 with `ready`=1. For a read, `DataMemoryOut` is valid in that cycle.
- Stall is therefore 2W+1 cycles per LDR/STR.
- A non-memory instruction never stalls.
- A new request in the cycle after DONE starts immediately, with no bubble.
- `sram_addr` and the write data are stable for all W cycles of each phase.

## Configuration
- Macro: `MEM_RANGE_CHECK_EN`.
- Defined:
  - A request is in error if `ALU_ResIn` < `BASE`, or off[1:0] ≠ 0, or off ≥ 2^(AW+1).
  - The FSM then goes IDLE → DONE directly, so `ready` is low for 1 cycle only.
  - The SRAM sees no access: `sram_we_n` stays 1.
  - For an erroneous read, `DataMemoryOut` becomes 0.
  - `err` is set and stays 1 until reset.
- Not defined: there is no checking, and `err` is tied to 0.

## Test plan
1. **Store.** W=2. STR 0xDEADBEEF to 1028.
   - `sram_addr`=2 with dq 0xBEEF and `sram_we_n`=0 for 2 cycles.
   - Then `sram_addr`=3 with dq 0xDEAD for 2 cycles.
   - `ready` low for 5 cycles, then high for 1.
2. **Load.** LDR from 1028 against an SRAM model.
   - `DataMemoryOut`=0xDEADBEEF in the DONE cycle (cycle 5).
   - `sram_dq_oe`=0 throughout.
3. **Non-memory instruction.** ADD with `WB_ENIn`=1, `ALU_ResIn`=0x55, `DestIn`=3.
   - `ready` stays 1 and `sram_we_n` stays 1.
   - The outputs pass through the same cycle.
4. **Back-to-back.** LDR immediately followed by STR.
   - The STR begins in the cycle after DONE.
   - Total `ready`-low cycles = 10.
5. **Reset mid-write.** Assert rst=0 at cycle 3 of a store.
   - `sram_we_n`=1, `ready`=1 and `DataMemoryOut`=0 immediately.
   - After release the FSM is in IDLE.
6. **Range check.** With `MEM_RANGE_CHECK_EN`, LDR from 1026.
   - `ready` low 1 cycle, `err`=1, `DataMemoryOut`=0, no SRAM activity.
   - Without the macro, the same access reads half-words 0 and 1.
